// File: rtl/comma_aligner.sv
// rtl/comma_aligner.sv - K28.5 comma detection and 10b word alignment for a serial bit stream
//
// Ports:
//   i_Clk        : clock, all logic on the rising edge
//   i_Rst        : asynchronous active-high reset
//   i_Data_In    : recovered serial bit
//   i_Bit_Valid  : i_Data_In carries a new bit this cycle
//   o_Word       : aligned 10b code group, first received bit in o_Word[9]
//   o_Word_Valid : one-cycle strobe qualifying o_Word
//   o_Comma      : o_Word is K28.5 (qualified by o_Word_Valid)
//   o_Aligned    : high while the aligner is LOCKED
//   o_Realign    : one-cycle pulse when the word boundary moves
module comma_aligner #(
    parameter int LOCK_CNT      = 2,
    parameter int MISALIGN_MAX  = 2,
    parameter int TIMEOUT_WORDS = 255
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Data_In,
    input  logic       i_Bit_Valid,
    output logic [9:0] o_Word,
    output logic       o_Word_Valid,
    output logic       o_Comma,
    output logic       o_Aligned,
    output logic       o_Realign
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISALIGN_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_WORDS + 1);

    localparam logic [GW-1:0] G_MAX  = GW'(LOCK_CNT);
    localparam logic [GW-1:0] G_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MISALIGN_MAX - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_WORDS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_WORDS - 1);

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [9:0]    sr, sr_nx, shifted, word_nx;
    logic [3:0]    bcnt, bcnt_nx;
    logic [GW-1:0] good, good_nx;
    logic [MW-1:0] mis, mis_nx;
    logic [TW-1:0] tout, tout_nx;
    logic          wv_nx, comma_nx, realign_nx;
    logic          is_comma, word_end, do_realign, do_emit;

    assign shifted  = {sr[8:0], i_Data_In};
    assign is_comma = (shifted == K28_5_NEG) || (shifted == K28_5_POS);
    assign word_end = (bcnt == 4'd9);

    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        bcnt_nx    = bcnt;
        good_nx    = good;
        mis_nx     = mis;
        tout_nx    = tout;
        word_nx    = o_Word;
        wv_nx      = 1'b0;
        comma_nx   = 1'b0;
        realign_nx = 1'b0;
        do_realign = 1'b0;
        do_emit    = 1'b0;

        if (i_Bit_Valid) begin
            sr_nx   = shifted;
            bcnt_nx = word_end ? 4'd0 : bcnt + 4'd1;

            case (state)
                HUNT: begin
                    if (is_comma) do_realign = 1'b1;
                end
                CHECK: begin
                    if (is_comma && !word_end) begin
                        do_realign = 1'b1;
                    end else if (word_end) begin
                        do_emit = 1'b1;
                        if (is_comma) begin
                            // an aligned comma beats a coincident timeout
                            tout_nx = '0;
                            good_nx = (good == G_MAX) ? good : good + GW'(1);
                            if (good >= G_LAST) state_nx = LOCKED;
                        end else begin
                            tout_nx = (tout == T_MAX) ? tout : tout + TW'(1);
                            if (tout >= T_LAST) state_nx = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (is_comma && !word_end) begin
                        // keep the old boundary until enough misaligned commas pile up
                        if (mis >= M_LAST) do_realign = 1'b1;
                        else               mis_nx = mis + MW'(1);
                    end else if (word_end) begin
                        do_emit = 1'b1;
                        if (is_comma) begin
                            mis_nx  = '0;
                            tout_nx = '0;
                        end else begin
                            tout_nx = (tout == T_MAX) ? tout : tout + TW'(1);
                            if (tout >= T_LAST) state_nx = HUNT;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase

            if (do_realign) begin
                // the comma itself closes a word; the next bit starts a fresh one
                word_nx    = shifted;
                wv_nx      = 1'b1;
                comma_nx   = 1'b1;
                realign_nx = 1'b1;
                bcnt_nx    = 4'd0;
                good_nx    = GW'(1);
                mis_nx     = '0;
                tout_nx    = '0;
                state_nx   = CHECK;
            end

            if (do_emit) begin
                word_nx  = shifted;
                wv_nx    = 1'b1;
                comma_nx = is_comma;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= HUNT;
        else       state <= state_nx;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sr           <= '0;
            bcnt         <= '0;
            good         <= '0;
            mis          <= '0;
            tout         <= '0;
            o_Word       <= '0;
            o_Word_Valid <= 1'b0;
            o_Comma      <= 1'b0;
            o_Realign    <= 1'b0;
            o_Aligned    <= 1'b0;
        end else begin
            sr           <= sr_nx;
            bcnt         <= bcnt_nx;
            good         <= good_nx;
            mis          <= mis_nx;
            tout         <= tout_nx;
            o_Word       <= word_nx;
            o_Word_Valid <= wv_nx;
            o_Comma      <= comma_nx;
            o_Realign    <= realign_nx;
            o_Aligned    <= (state_nx == LOCKED);
        end
    end

endmodule

// File: tb/tb_comma_aligner.sv
// tb/tb_comma_aligner.sv - directed table-driven bench for comma_aligner
module tb_comma_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       bv  = 1'b0;

    logic [9:0] a_word, b_word;
    logic       a_wv, a_comma, a_aligned, a_realign;
    logic       b_wv, b_comma, b_aligned, b_realign;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comma_aligner dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Data_In(din), .i_Bit_Valid(bv),
        .o_Word(a_word), .o_Word_Valid(a_wv), .o_Comma(a_comma),
        .o_Aligned(a_aligned), .o_Realign(a_realign)
    );

    comma_aligner #(.TIMEOUT_WORDS(4)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Data_In(din), .i_Bit_Valid(bv),
        .o_Word(b_word), .o_Word_Valid(b_wv), .o_Comma(b_comma),
        .o_Aligned(b_aligned), .o_Realign(b_realign)
    );

    typedef struct {
        logic [12:0] bits;
        int          nbits;
        int          n_strobe;
        logic [9:0]  word;
        logic        comma;
        logic        realign;
        logic        aligned;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        @(negedge clk);
        din = b;
        bv  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bv  = 1'b0;
        din = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_group(input logic [12:0] bits, input int nbits,
                              output int ns, output logic [9:0] w,
                              output logic c, output logic r);
        ns = 0; w = '0; c = 1'b0; r = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            step(bits[i], 1'b1);
            if (a_wv) begin
                ns++;
                w = a_word;
                c = a_comma;
            end
            if (a_realign) r = 1'b1;
        end
    endtask

    initial begin
        int         ns, nb, st_idx;
        logic [9:0] w, wd;
        logic       c, r;
        logic [9:0] seq[3];
        int         st_cyc[3];
        logic [9:0] st_word[3];
        logic       al_at[4];

        seq[0] = 10'h0FA; seq[1] = 10'h274; seq[2] = 10'h305;

        tbl[0] = '{13'h0FA, 10, 1, 10'h0FA, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{13'h274, 10, 1, 10'h274, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{13'h305, 10, 1, 10'h305, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{13'h274, 10, 1, 10'h274, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{13'h305, 10, 1, 10'h305, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{13'h0FA, 13, 1, 10'h01F, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{13'h0FA, 10, 2, 10'h0FA, 1'b1, 1'b1, 1'b0};

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_a_word", 32'(a_word), 32'h0);
        check("rst_a_flags", {28'h0, a_wv, a_comma, a_aligned, a_realign}, 32'h0);
        check("rst_b_word", 32'(b_word), 32'h0);
        check("rst_b_flags", {28'h0, b_wv, b_comma, b_aligned, b_realign}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // acquisition, lock and misaligned-comma realignment
        for (int k = 0; k < 7; k++) begin
            send_group(tbl[k].bits, tbl[k].nbits, ns, w, c, r);
            check($sformatf("v%0d_nstrobe", k), 32'(ns), 32'(tbl[k].n_strobe));
            check($sformatf("v%0d_word", k), 32'(w), 32'(tbl[k].word));
            check($sformatf("v%0d_comma", k), 32'(c), 32'(tbl[k].comma));
            check($sformatf("v%0d_realign", k), 32'(r), 32'(tbl[k].realign));
            check($sformatf("v%0d_aligned", k), 32'(a_aligned), 32'(tbl[k].aligned));
        end
        send_group(13'h305, 10, ns, w, c, r);
        check("relock_aligned", 32'(a_aligned), 32'h1);

        // reset between edges, mid-word
        for (int i = 0; i < 5; i++) step(1'(i & 1), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_word", 32'(a_word), 32'h0);
        check("midrst_flags", {28'h0, a_wv, a_comma, a_aligned, a_realign}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        for (int k = 0; k < 3; k++) begin
            send_group(13'h274, 10, ns, w, c, r);
            nb += ns;
        end
        check("midrst_no_strobe", 32'(nb), 32'h0);
        check("midrst_aligned", 32'(a_aligned), 32'h0);

        // sparse bit valid: one valid bit every other cycle
        do_reset();
        st_idx = 0;
        for (int k = 0; k < 3; k++) begin
            wd = seq[k];
            for (int i = 9; i >= 0; i--) begin
                for (int v = 1; v >= 0; v--) begin
                    step(v[0] ? wd[i] : 1'b0, v[0]);
                    if (a_wv) begin
                        if (st_idx < 3) begin
                            st_cyc[st_idx]  = cyc;
                            st_word[st_idx] = a_word;
                        end
                        st_idx++;
                    end
                end
            end
        end
        check("sparse_nstrobe", 32'(st_idx), 32'h3);
        if (st_idx == 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("sparse_word%0d", k), 32'(st_word[k]), 32'(seq[k]));
            check("sparse_gap01", 32'(st_cyc[1] - st_cyc[0]), 32'd20);
            check("sparse_gap12", 32'(st_cyc[2] - st_cyc[1]), 32'd20);
        end
        check("sparse_aligned", 32'(a_aligned), 32'h1);

        // timeout with TIMEOUT_WORDS=4 on dut_b
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wd = seq[k];
            for (int i = 9; i >= 0; i--) step(wd[i], 1'b1);
        end
        check("to_locked", 32'(b_aligned), 32'h1);
        nb = 0;
        wd = 10'h274;
        for (int k = 0; k < 4; k++) begin
            for (int i = 9; i >= 0; i--) begin
                step(wd[i], 1'b1);
                if (b_wv) begin
                    if (nb < 4) al_at[nb] = b_aligned;
                    nb++;
                end
            end
        end
        check("to_nstrobe", 32'(nb), 32'h4);
        if (nb == 4) begin
            check("to_aligned_3rd", 32'(al_at[2]), 32'h1);
            check("to_aligned_4th", 32'(al_at[3]), 32'h0);
        end
        nb = 0;
        for (int i = 9; i >= 0; i--) begin
            step(wd[i], 1'b1);
            if (b_wv) nb++;
        end
        check("to_hunt_no_strobe", 32'(nb), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comma_aligner.md
COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 2: aligned K28.5 commas, including the acquiring one, required in CHECK to reach LOCKED.
REQ-002 SHALL have parameter MISALIGN_MAX, default 2: consecutive misaligned commas in LOCKED that force realignment.
REQ-003 SHALL have parameter TIMEOUT_WORDS, default 255: words emitted without an aligned comma before dropping to HUNT.
REQ-004 SHALL have port i_Clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_Data_In, input, 1: recovered serial bit from the FIFO output.
REQ-007 SHALL have port i_Bit_Valid, input, 1: i_Data_In is a new bit this cycle.
REQ-008 SHALL have port o_Word, output, 10: aligned 10b code group for the 10b/8b decoder.
REQ-009 SHALL have port o_Word_Valid, output, 1: single-cycle strobe qualifying o_Word.
REQ-010 SHALL have port o_Comma, output, 1: o_Word is K28.5; valid only with o_Word_Valid.
REQ-011 SHALL have port o_Aligned, output, 1: high while in LOCKED.
REQ-012 SHALL have port o_Realign, output, 1: single-cycle pulse when the word boundary moves.

Function
REQ-013 SHALL shift bits MSB-first: on i_Bit_Valid, shift register sr <= {sr[8:0], i_Data_In}, so the first bit received lands in o_Word[9].
REQ-014 SHALL compare the next sr value, {sr[8:0], i_Data_In}, against 10'b0011111010 (RD-) and 10'b1100000101 (RD+) on every valid bit.
REQ-015 SHALL keep bit counter bcnt over 0..9; a word completes on a valid bit with bcnt==9, and bcnt then wraps to 0.
REQ-016 SHALL classify a comma match as aligned when bcnt==9 and misaligned otherwise.
REQ-017 SHALL register outputs: o_Word, o_Word_Valid and o_Comma appear on the edge after the completing valid bit; latency is 1 cycle.
REQ-018 SHALL hold all state and produce no strobes when i_Bit_Valid=0.
REQ-019 SHALL implement states HUNT, CHECK, LOCKED with 2-bit encoding.
REQ-020 HUNT: o_Word_Valid=0 except on a comma match, which emits the comma word, sets bcnt=0 and good=1, pulses o_Realign, and goes to CHECK.
REQ-021 CHECK: emit every completed word; an aligned comma increments good; when good reaches LOCK_CNT, go to LOCKED.
REQ-022 CHECK: a misaligned comma realigns immediately: drop the partial word, emit the comma word, set good=1, set bcnt=0, pulse o_Realign.
REQ-023 LOCKED: emit every word; an aligned comma clears the misalign and timeout counters.
REQ-024 LOCKED: a misaligned comma increments misalign; the partial word at the old boundary is retained.
REQ-025 LOCKED: when misalign reaches MISALIGN_MAX, realign on that comma per REQ-022 and go to CHECK.
REQ-026 SHALL count emitted non-comma words in CHECK and LOCKED; when the count reaches TIMEOUT_WORDS, go to HUNT with that word still emitted.
REQ-027 SHALL give an aligned comma on the same word as a timeout priority: it resets the counter and the state is kept.
REQ-028 SHALL size counters by $clog2(max+1) and saturate them, never wrapping.
REQ-029 SHALL drive o_Aligned from a registered state: it rises on the edge that enters LOCKED and falls on the edge that leaves it.

Reset
REQ-030 While i_Rst=1: state=HUNT; sr, bcnt, good, misalign, timeout = 0; o_Word=0; o_Word_Valid=o_Comma=o_Aligned=o_Realign=0; all immediately and independent of i_Clk.
REQ-031 Reset mid-word SHALL discard the partial word; reacquisition requires a new comma.
REQ-032 Deassertion SHALL take effect at the first i_Clk rising edge after release; the bit on that edge is accepted.

Verification
REQ-033 Reset, then 10 valid bits 0011111010 -> next cycle o_Word=10'h0FA, o_Word_Valid=1, o_Comma=1, o_Realign=1, o_Aligned=0.
REQ-034 Continue with 1001110100 then 1100000101 -> words 0x274 (o_Comma=0) and 0x305 (o_Comma=1); o_Aligned=1 on the same edge as the 0x305 strobe.
REQ-035 In LOCKED, send 3 filler bits then K28.5 RD- twice -> first comma: o_Aligned stays 1, no o_Realign; second comma: o_Realign=1, o_Word=0x0FA, o_Aligned=0.
REQ-036 Repeat REQ-033/034 with i_Bit_Valid toggling every cycle -> identical word sequence, strobes spaced 20 cycles apart.
REQ-037 TIMEOUT_WORDS=4, LOCKED, then 4 words 0x274 -> 4 strobes, o_Aligned falls with the 4th, no strobe on the following 10 bits.
REQ-038 Assert i_Rst between clock edges after 5 bits -> all outputs 0 immediately; 0x274 words afterward yield no strobe.
